// File: rtl/console_writer_if.sv
// Bundles the console writer's key-input handshake, VRAM write/read bus and
// cursor/status outputs so the writer and its surroundings share one port.
interface console_writer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_code;
    logic        in_dir;
    logic        vram_we;
    logic [11:0] vram_waddr;
    logic [7:0]  vram_wdata;
    logic [11:0] vram_raddr;
    logic [7:0]  vram_rdata;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;

    // Side that supplies key codes and owns the video RAM
    modport master (
        output in_valid,
        output in_code,
        output in_dir,
        output vram_rdata,
        input  in_ready,
        input  vram_we,
        input  vram_waddr,
        input  vram_wdata,
        input  vram_raddr,
        input  cur_x,
        input  cur_y,
        input  busy
    );

    // Console writer side
    modport slave (
        input  in_valid,
        input  in_code,
        input  in_dir,
        input  vram_rdata,
        output in_ready,
        output vram_we,
        output vram_waddr,
        output vram_wdata,
        output vram_raddr,
        output cur_x,
        output cur_y,
        output busy
    );
endinterface

// File: rtl/console_writer.sv
// Text-console writer: takes key codes, tracks the cursor and fills the
// character VRAM (word address {row[4:0], col[6:0]}). Clears the screen after
// reset, handles printable chars, Enter, Backspace, arrows and scrolls the
// screen up by copying rows through the VRAM read port. All outputs are
// registered; a write decided at edge T is visible (we=1) during cycle T+1.
module console_writer #(
    parameter int         COLS     = 70,
    parameter int         ROWS     = 30,
    parameter logic [7:0] PROMPT   = 8'h3E,
    parameter int         PROMPT_X = 2
) (
    input  logic             clk,
    input  logic             rst,
    console_writer_if.slave  bus
);

    localparam logic [6:0] LAST_COL      = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW      = 5'(ROWS - 1);
    localparam logic [4:0] LAST_COPY_ROW = 5'(ROWS - 2);
    localparam logic [6:0] PROMPT_COL    = 7'(PROMPT_X);
    localparam logic [7:0] CODE_ENTER    = 8'h0D;
    localparam logic [7:0] CODE_BACK     = 8'h08;
    localparam logic [7:0] DIR_DOWN      = 8'h32;
    localparam logic [7:0] DIR_LEFT      = 8'h34;
    localparam logic [7:0] DIR_RIGHT     = 8'h36;
    localparam logic [7:0] DIR_UP        = 8'h38;

    typedef enum logic [2:0] {
        INIT_CLR,
        INIT_PROMPT,
        IDLE,
        SCR_RD,
        SCR_WR,
        SCR_CLR,
        SCR_POST
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] init_cnt_q, init_cnt_d;
    logic [4:0]  scr_row_q, scr_row_d;
    logic [6:0]  scr_col_q, scr_col_d;
    logic        post_prompt_q, post_prompt_d;
    logic [6:0]  cur_x_q, cur_x_d;
    logic [4:0]  cur_y_q, cur_y_d;
    logic        we_q, we_d;
    logic [11:0] waddr_q, waddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [11:0] raddr_q, raddr_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;

    logic        fire;
    logic        start_scroll;
    logic        is_printable;

    assign fire         = bus.in_valid & in_ready_q;
    assign is_printable = !bus.in_dir && (bus.in_code != CODE_ENTER)
                          && (bus.in_code != CODE_BACK);

    // Next-state, cursor and VRAM-port decisions for every state
    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        scr_row_d     = scr_row_q;
        scr_col_d     = scr_col_q;
        post_prompt_d = post_prompt_q;
        cur_x_d       = cur_x_q;
        cur_y_d       = cur_y_q;
        we_d          = 1'b0;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        raddr_d       = raddr_q;
        in_ready_d    = in_ready_q;
        busy_d        = busy_q;
        start_scroll  = 1'b0;

        case (state_q)
            INIT_CLR: begin
                we_d       = 1'b1;
                waddr_d    = init_cnt_q;
                wdata_d    = 8'h00;
                init_cnt_d = init_cnt_q + 12'd1;
                if (init_cnt_q == 12'hFFF) begin
                    state_d = INIT_PROMPT;
                end
            end

            INIT_PROMPT: begin
                we_d       = 1'b1;
                waddr_d    = 12'h000;
                wdata_d    = PROMPT;
                state_d    = IDLE;
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
            end

            IDLE: begin
                if (fire) begin
                    if (bus.in_dir) begin
                        case (bus.in_code)
                            DIR_DOWN: begin
                                if (cur_y_q < LAST_ROW) begin
                                    cur_y_d = cur_y_q + 5'd1;
                                end
                            end
                            DIR_UP: begin
                                if (cur_y_q != 5'd0) begin
                                    cur_y_d = cur_y_q - 5'd1;
                                end
                            end
                            DIR_LEFT: begin
                                if (cur_x_q != 7'd0) begin
                                    cur_x_d = cur_x_q - 7'd1;
                                end
                            end
                            DIR_RIGHT: begin
                                if (cur_x_q < LAST_COL) begin
                                    cur_x_d = cur_x_q + 7'd1;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end else if (bus.in_code == CODE_ENTER) begin
                        cur_x_d = PROMPT_COL;
                        if (cur_y_q < LAST_ROW) begin
                            we_d    = 1'b1;
                            waddr_d = {cur_y_q + 5'd1, 7'd0};
                            wdata_d = PROMPT;
                            cur_y_d = cur_y_q + 5'd1;
                        end else begin
                            start_scroll  = 1'b1;
                            post_prompt_d = 1'b1;
                        end
                    end else if (bus.in_code == CODE_BACK) begin
                        if (cur_x_q != 7'd0) begin
                            we_d    = 1'b1;
                            waddr_d = {cur_y_q, cur_x_q - 7'd1};
                            wdata_d = 8'h00;
                            cur_x_d = cur_x_q - 7'd1;
                        end else if (cur_y_q != 5'd0) begin
                            we_d    = 1'b1;
                            waddr_d = {cur_y_q - 5'd1, LAST_COL};
                            wdata_d = 8'h00;
                            cur_x_d = LAST_COL;
                            cur_y_d = cur_y_q - 5'd1;
                        end
                    end else if (is_printable) begin
                        we_d    = 1'b1;
                        waddr_d = {cur_y_q, cur_x_q};
                        wdata_d = bus.in_code;
                        if (cur_x_q < LAST_COL) begin
                            cur_x_d = cur_x_q + 7'd1;
                        end else if (cur_y_q < LAST_ROW) begin
                            cur_x_d = 7'd0;
                            cur_y_d = cur_y_q + 5'd1;
                        end else begin
                            cur_x_d       = 7'd0;
                            start_scroll  = 1'b1;
                            post_prompt_d = 1'b0;
                        end
                    end
                end

                // The first read address is presented during the first SCR_RD cycle
                if (start_scroll) begin
                    state_d    = SCR_RD;
                    scr_row_d  = 5'd0;
                    scr_col_d  = 7'd0;
                    raddr_d    = {5'd1, 7'd0};
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            SCR_RD: begin
                state_d = SCR_WR;
            end

            SCR_WR: begin
                we_d    = 1'b1;
                waddr_d = {scr_row_q, scr_col_q};
                wdata_d = bus.vram_rdata;
                if (scr_col_q == LAST_COL) begin
                    scr_col_d = 7'd0;
                    if (scr_row_q == LAST_COPY_ROW) begin
                        state_d = SCR_CLR;
                    end else begin
                        scr_row_d = scr_row_q + 5'd1;
                        raddr_d   = {scr_row_q + 5'd2, 7'd0};
                        state_d   = SCR_RD;
                    end
                end else begin
                    scr_col_d = scr_col_q + 7'd1;
                    raddr_d   = {scr_row_q + 5'd1, scr_col_q + 7'd1};
                    state_d   = SCR_RD;
                end
            end

            SCR_CLR: begin
                we_d    = 1'b1;
                waddr_d = {LAST_ROW, scr_col_q};
                wdata_d = 8'h00;
                if (scr_col_q == LAST_COL) begin
                    scr_col_d = 7'd0;
                    state_d   = SCR_POST;
                end else begin
                    scr_col_d = scr_col_q + 7'd1;
                end
            end

            SCR_POST: begin
                if (post_prompt_q) begin
                    we_d    = 1'b1;
                    waddr_d = {LAST_ROW, 7'd0};
                    wdata_d = PROMPT;
                end
                post_prompt_d = 1'b0;
                state_d       = IDLE;
                in_ready_d    = 1'b1;
                busy_d        = 1'b0;
            end

            default: begin
                state_d = INIT_CLR;
            end
        endcase
    end

    // State and output registers; reset restarts the screen clear from scratch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= INIT_CLR;
            init_cnt_q    <= 12'd0;
            scr_row_q     <= 5'd0;
            scr_col_q     <= 7'd0;
            post_prompt_q <= 1'b0;
            cur_x_q       <= PROMPT_COL;
            cur_y_q       <= 5'd0;
            we_q          <= 1'b0;
            waddr_q       <= 12'd0;
            wdata_q       <= 8'h00;
            raddr_q       <= 12'd0;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            scr_row_q     <= scr_row_d;
            scr_col_q     <= scr_col_d;
            post_prompt_q <= post_prompt_d;
            cur_x_q       <= cur_x_d;
            cur_y_q       <= cur_y_d;
            we_q          <= we_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            raddr_q       <= raddr_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.vram_we    = we_q;
    assign bus.vram_waddr = waddr_q;
    assign bus.vram_wdata = wdata_q;
    assign bus.vram_raddr = raddr_q;
    assign bus.cur_x      = cur_x_q;
    assign bus.cur_y      = cur_y_q;
    assign bus.busy       = busy_q;

endmodule
